// File: rtl/fw_fetch_pkg.sv
`default_nettype none
// ============================================================================
// fw_fetch_pkg - shared types for the fwrisc fetch front end.  Rev 1.0
// ============================================================================
package fw_fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage : fw_fetch_pkg
`default_nettype wire

// File: rtl/fw_fetch_fifo.sv
`default_nettype none
// ============================================================================
// fw_fetch_fifo - instruction buffer of fetch_entry_t with wrapping pointers.  Rev 1.0
// ============================================================================
module fw_fetch_fifo
  import fw_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule : fw_fetch_fifo
`default_nettype wire

// File: rtl/fw_fetch_unit.sv
`default_nettype none
// ============================================================================
// fw_fetch_unit - PC, fetch request FSM and redirect handling for fwrisc.  Rev 1.0
// ============================================================================
module fw_fetch_unit
  import fw_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic [31:0] idata,
  input  logic        iready,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         ivalid_q;
  logic         boot_arm_q;

  logic         accept;
  logic         push;
  logic         pop;
  logic         fills;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign accept     = ivalid_q & iready;
  assign push       = accept & ~redirect_valid;
  assign pop        = ~fifo_empty & fetch_ready;
  assign fills      = push & ~pop & (fifo_count == CW'(DEPTH - 1));
  assign pc_d       = pc_q + 32'(INSTR_BYTES);
  assign push_entry = '{instr: idata, pc: pc_q};

  fw_fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (push_entry),
    .pop     (pop),
    .flush   (redirect_valid),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (head)
  );

  // boot_arm_q delays the first request by one cycle after reset release.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      ivalid_q   <= 1'b0;
      boot_arm_q <= 1'b0;
    end else begin
      boot_arm_q <= 1'b1;
      if (redirect_valid) begin
        state_q  <= FETCH;
        ivalid_q <= 1'b1;
        pc_q     <= {redirect_pc[31:2], 2'b00};
      end else begin
        case (state_q)
          BOOT: begin
            if (boot_arm_q) begin
              state_q  <= FETCH;
              ivalid_q <= 1'b1;
            end
          end
          FETCH: begin
            if (accept) begin
              pc_q <= pc_d;
            end
            if (fills) begin
              state_q  <= FULL;
              ivalid_q <= 1'b0;
            end
          end
          FULL: begin
            if (pop || !fifo_full) begin
              state_q  <= FETCH;
              ivalid_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= BOOT;
            ivalid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ivalid      = ivalid_q;
  assign iaddr       = pc_q;
  assign fetch_valid = ~fifo_empty;
  assign fetch_instr = head.instr;
  assign fetch_pc    = head.pc;

endmodule : fw_fetch_unit
`default_nettype wire
